// File: rtl/adc_rx_pkg.sv
// Shared widths, the peak record layout and the FSM state type for the
// peak window detector.
package adc_rx_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int INDEX_WIDTH = 5;
  localparam int POS_WIDTH   = 16;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  value;
    logic [INDEX_WIDTH-1:0] index;
    logic [POS_WIDTH-1:0]   pos;
  } peak_rec_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } pwd_state_t;

endpackage

// File: rtl/peak_window_detector_if.sv
// Strobe input from the max tree and the peak record output stream.
// Handshakes: a strobe is taken on any edge with IDAV=1 (no back-pressure);
// a record transfers on an edge where PEAK_DAV=1 and PEAK_RDY=1, and the
// head fields hold steady while PEAK_DAV=1 and PEAK_RDY=0.
interface peak_window_detector_if;

  logic [adc_rx_pkg::DATA_WIDTH-1:0]  IVALUE;
  logic [adc_rx_pkg::INDEX_WIDTH-1:0] IINDEX;
  logic                               IDAV;
  logic [adc_rx_pkg::DATA_WIDTH-1:0]  PEAK_VALUE;
  logic [adc_rx_pkg::INDEX_WIDTH-1:0] PEAK_INDEX;
  logic [adc_rx_pkg::POS_WIDTH-1:0]   PEAK_POS;
  logic                               PEAK_DAV;
  logic                               PEAK_RDY;

  modport master (
    input  IVALUE, IINDEX, IDAV, PEAK_RDY,
    output PEAK_VALUE, PEAK_INDEX, PEAK_POS, PEAK_DAV
  );

  modport slave (
    output IVALUE, IINDEX, IDAV, PEAK_RDY,
    input  PEAK_VALUE, PEAK_INDEX, PEAK_POS, PEAK_DAV
  );

endinterface

// File: rtl/peak_rec_fifo.sv
// First-word-fall-through record FIFO built as a shift register so the head
// entry is always a flop; a push when full without a pop is discarded.
module peak_rec_fifo
  import adc_rx_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  peak_rec_t     din,
  input  logic          pop,
  output peak_rec_t     head,
  output logic          head_valid,
  output logic          full,
  output logic [LW-1:0] level
);

  peak_rec_t      mem [DEPTH];
  logic [LW-1:0]  count_q;
  logic           do_pop;
  logic           do_push;
  logic [LW-1:0]  wr_idx;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != LW'(DEPTH)) || do_pop);
    // Entries shift down on a pop, so the write slot moves down with them.
    wr_idx  = count_q - (do_pop ? LW'(1) : LW'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count_q <= count_q + (do_push ? LW'(1) : LW'(0)) - (do_pop ? LW'(1) : LW'(0));
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && (LW'(i) == wr_idx)) mem[i] <= din;
        else if (do_pop && (i < DEPTH - 1)) mem[i] <= mem[(i + 1) % DEPTH];
      end
    end
  end

  assign head       = mem[0];
  assign head_valid = (count_q != '0);
  assign full       = (count_q == LW'(DEPTH));
  assign level      = count_q;

endmodule

// File: rtl/peak_window_detector.sv
// Finds the largest above-threshold maximum in each window of N strobes and
// queues its value/index/position; windows run back-to-back while ENABLE=1.
module peak_window_detector
  import adc_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ENABLE,
  input  logic [DATA_WIDTH-1:0]        THRESHOLD,
  input  logic [POS_WIDTH-1:0]         WINDOW_LEN,
  input  logic                         CLR_OVF,
  peak_window_detector_if.master       pk,
  output logic [$clog2(FIFO_DEPTH):0]  FIFO_LEVEL,
  output logic                         OVERFLOW,
  output pwd_state_t                   dbg_state
);

  pwd_state_t             state_q;
  logic [DATA_WIDTH-1:0]  thr_q;
  logic [POS_WIDTH-1:0]   len_q;
  logic [POS_WIDTH-1:0]   cnt_q;
  logic                   found_q;
  peak_rec_t              peak_q;
  logic                   ovf_q;

  logic [POS_WIDTH-1:0]   len_eff;
  logic                   sample;
  logic                   qualifies;
  logic                   take;
  logic                   cur_found;
  peak_rec_t              cur_rec;
  logic                   win_end;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   head_valid;
  peak_rec_t              head;

  always_comb begin
    len_eff   = (WINDOW_LEN == '0) ? POS_WIDTH'(1) : WINDOW_LEN;
    sample    = (state_q == ST_COLLECT) && ENABLE && pk.IDAV;
    qualifies = pk.IVALUE >= thr_q;
    // Strict compare keeps the earliest sample on a tie.
    take      = qualifies && (!found_q || (pk.IVALUE > peak_q.value));
    cur_found = found_q || qualifies;
    cur_rec   = peak_q;
    if (take) begin
      cur_rec.value = pk.IVALUE;
      cur_rec.index = pk.IINDEX;
      cur_rec.pos   = cnt_q;
    end
    win_end   = sample && (cnt_q == len_q - 1'b1);
    push      = win_end && cur_found;
    pop       = head_valid && pk.PEAK_RDY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      thr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      peak_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push && full && !pop) ovf_q <= 1'b1;
      else if (CLR_OVF)         ovf_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (ENABLE) begin
            state_q <= ST_COLLECT;
            thr_q   <= THRESHOLD;
            len_q   <= len_eff;
            cnt_q   <= '0;
            found_q <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (!ENABLE) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            found_q <= 1'b0;
          end else if (pk.IDAV) begin
            if (win_end) begin
              thr_q   <= THRESHOLD;
              len_q   <= len_eff;
              cnt_q   <= '0;
              found_q <= 1'b0;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              peak_q  <= cur_rec;
              found_q <= cur_found;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  peak_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .din        (cur_rec),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .full       (full),
    .level      (FIFO_LEVEL)
  );

  assign pk.PEAK_VALUE = head.value;
  assign pk.PEAK_INDEX = head.index;
  assign pk.PEAK_POS   = head.pos;
  assign pk.PEAK_DAV   = head_valid;
  assign OVERFLOW      = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_peak_window_detector.sv
// Directed bench for peak_window_detector: a table of single windows plus
// hand-written sequences for overflow, abort, async reset and streaming.
module tb_peak_window_detector;
  import adc_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ENABLE;
  logic        CLR_OVF;
  logic [15:0] THRESHOLD;
  logic [15:0] WINDOW_LEN;
  logic [2:0]  FIFO_LEVEL;
  logic        OVERFLOW;
  pwd_state_t  dbg_state;

  peak_window_detector_if pif ();

  int tests_run    = 0;
  int tests_failed = 0;
  logic [36:0] exp_q[$];

  typedef struct {
    logic [15:0] thr;
    logic [15:0] v [4];
    logic [4:0]  ix [4];
    logic        found;
    logic [15:0] pv;
    logic [4:0]  pi;
    logic [15:0] pp;
  } vec_t;

  vec_t vecs [7];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  peak_window_detector #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ENABLE     (ENABLE),
    .THRESHOLD  (THRESHOLD),
    .WINDOW_LEN (WINDOW_LEN),
    .CLR_OVF    (CLR_OVF),
    .pk         (pif),
    .FIFO_LEVEL (FIFO_LEVEL),
    .OVERFLOW   (OVERFLOW),
    .dbg_state  (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] v, input logic [4:0] ix);
    pif.IVALUE = v;
    pif.IINDEX = ix;
    pif.IDAV   = 1'b1;
    tick();
    pif.IDAV   = 1'b0;
  endtask

  task automatic start(input logic [15:0] thr, input logic [15:0] len);
    ENABLE = 1'b0;
    tick();
    THRESHOLD  = thr;
    WINDOW_LEN = len;
    ENABLE     = 1'b1;
    tick();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_head(input string name, input peak_rec_t r);
    check({name, "_dav"},   pif.PEAK_DAV,   1);
    check({name, "_value"}, pif.PEAK_VALUE, r.value);
    check({name, "_index"}, pif.PEAK_INDEX, r.index);
    check({name, "_pos"},   pif.PEAK_POS,   r.pos);
  endtask

  initial begin
    peak_rec_t r;

    vecs[0] = '{thr:100,   v:'{50, 300, 200, 300},       ix:'{3, 7, 9, 12}, found:1, pv:300,   pi:7,  pp:1};
    vecs[1] = '{thr:100,   v:'{10, 20, 99, 0},           ix:'{1, 2, 3, 4},  found:0, pv:0,     pi:0,  pp:0};
    vecs[2] = '{thr:5,     v:'{40, 40, 40, 40},          ix:'{1, 2, 3, 4},  found:1, pv:40,    pi:1,  pp:0};
    vecs[3] = '{thr:0,     v:'{1, 2, 3, 65535},          ix:'{0, 1, 2, 31}, found:1, pv:65535, pi:31, pp:3};
    vecs[4] = '{thr:77,    v:'{77, 10, 5, 76},           ix:'{9, 8, 7, 6},  found:1, pv:77,    pi:9,  pp:0};
    vecs[5] = '{thr:200,   v:'{199, 201, 150, 200},      ix:'{5, 6, 7, 8},  found:1, pv:201,   pi:6,  pp:1};
    vecs[6] = '{thr:65535, v:'{65535, 65534, 0, 65535},  ix:'{1, 2, 3, 4},  found:1, pv:65535, pi:1,  pp:0};

    rst_n = 1'b0; ENABLE = 1'b0; CLR_OVF = 1'b0;
    THRESHOLD = '0; WINDOW_LEN = '0;
    pif.IVALUE = '0; pif.IINDEX = '0; pif.IDAV = 1'b0; pif.PEAK_RDY = 1'b0;
    #3;
    check("reset_dav",   pif.PEAK_DAV, 0);
    check("reset_level", FIFO_LEVEL,   0);
    check("reset_ovf",   OVERFLOW,     0);
    check("reset_state", dbg_state,    ST_IDLE);
    #20 rst_n = 1'b1;
    tick();

    // Table: one 4-strobe window per vector, consumer always ready.
    pif.PEAK_RDY = 1'b1;
    for (int k = 0; k < 7; k++) begin
      start(vecs[k].thr, 16'd4);
      for (int s = 0; s < 4; s++) begin
        strobe(vecs[k].v[s], vecs[k].ix[s]);
        if (s == 2) check($sformatf("v%0d_dav_early", k), pif.PEAK_DAV, 0);
      end
      check($sformatf("v%0d_dav", k), pif.PEAK_DAV, vecs[k].found);
      check($sformatf("v%0d_level", k), FIFO_LEVEL, vecs[k].found ? 1 : 0);
      if (vecs[k].found) begin
        check($sformatf("v%0d_value", k), pif.PEAK_VALUE, vecs[k].pv);
        check($sformatf("v%0d_index", k), pif.PEAK_INDEX, vecs[k].pi);
        check($sformatf("v%0d_pos", k),   pif.PEAK_POS,   vecs[k].pp);
      end
      tick();
      check($sformatf("v%0d_drained", k), pif.PEAK_DAV, 0);
      check($sformatf("v%0d_ovf", k), OVERFLOW, 0);
    end

    // Overflow: five 2-strobe windows into a 4-deep FIFO with no consumer.
    pif.PEAK_RDY = 1'b0;
    start(16'd0, 16'd2);
    for (int w = 1; w <= 5; w++) begin
      strobe(16'(w * 10 + 1), 5'(w));
      strobe(16'(w * 10 + 5), 5'(w + 10));
      r.value = 16'(w * 10 + 5); r.index = 5'(w + 10); r.pos = 16'd1;
      if (w <= 4) exp_q.push_back(r);
    end
    check("ovf_level", FIFO_LEVEL, 4);
    check("ovf_set",   OVERFLOW,   1);
    ENABLE = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      r = exp_q.pop_front();
      check_head($sformatf("ovf_drain%0d", k), r);
      pif.PEAK_RDY = 1'b1;
      tick();
      pif.PEAK_RDY = 1'b0;
    end
    check("ovf_empty",  pif.PEAK_DAV, 0);
    check("ovf_sticky", OVERFLOW,     1);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    check("ovf_clear",  OVERFLOW,     0);

    // Abort: ENABLE drops after two strobes; the IDAV in that cycle is ignored.
    pif.PEAK_RDY = 1'b1;
    start(16'd0, 16'd4);
    strobe(16'd100, 5'd1);
    strobe(16'd500, 5'd2);
    pif.IVALUE = 16'd600; pif.IDAV = 1'b1; ENABLE = 1'b0;
    tick();
    pif.IDAV = 1'b0;
    check("abort_state", dbg_state,    ST_IDLE);
    check("abort_dav",   pif.PEAK_DAV, 0);
    check("abort_level", FIFO_LEVEL,   0);
    ENABLE = 1'b1;
    tick();
    strobe(16'd90, 5'd3);
    strobe(16'd20, 5'd4);
    strobe(16'd5,  5'd5);
    strobe(16'd7,  5'd6);
    r.value = 16'd90; r.index = 5'd3; r.pos = 16'd0;
    check_head("rearm", r);
    tick();

    // Async reset mid-window with two records queued.
    pif.PEAK_RDY = 1'b0;
    start(16'd0, 16'd1);
    strobe(16'd11, 5'd1);
    WINDOW_LEN = 16'd4;
    strobe(16'd22, 5'd2);
    strobe(16'd999, 5'd3);
    check("prerst_level", FIFO_LEVEL, 2);
    #2 rst_n = 1'b0;
    ENABLE = 1'b0;
    #1;
    check("arst_dav",   pif.PEAK_DAV,   0);
    check("arst_value", pif.PEAK_VALUE, 0);
    check("arst_index", pif.PEAK_INDEX, 0);
    check("arst_pos",   pif.PEAK_POS,   0);
    check("arst_level", FIFO_LEVEL,     0);
    check("arst_ovf",   OVERFLOW,       0);
    check("arst_state", dbg_state,      ST_IDLE);
    rst_n = 1'b1;
    tick();
    tick();
    check("postrst_dav",   pif.PEAK_DAV, 0);
    check("postrst_state", dbg_state,    ST_IDLE);

    // Streaming: WINDOW_LEN=0 acts as 1, FIFO full, push and pop every cycle.
    exp_q.delete();
    start(16'd0, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      strobe(16'(k), 5'(k));
      r.value = 16'(k); r.index = 5'(k); r.pos = 16'd0;
      exp_q.push_back(r);
    end
    check("stream_fill", FIFO_LEVEL, 4);
    pif.PEAK_RDY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check_head($sformatf("stream%0d", k), peak_rec_t'(exp_q[0]));
      strobe(16'(100 + k), 5'(k));
      void'(exp_q.pop_front());
      r.value = 16'(100 + k); r.index = 5'(k); r.pos = 16'd0;
      exp_q.push_back(r);
      check($sformatf("stream%0d_level", k), FIFO_LEVEL, 4);
      check($sformatf("stream%0d_ovf", k),   OVERFLOW,   0);
    end
    ENABLE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r = exp_q.pop_front();
      check_head($sformatf("stream_drain%0d", k), r);
      tick();
    end
    check("stream_empty", FIFO_LEVEL, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
